// File: rtl/sdrc_mport_ctrl_if.sv
// rtl/sdrc_mport_ctrl_if.sv - host write/read ports and sdrc command/data bundle for sdrc_mport_ctrl
interface sdrc_mport_ctrl_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32,
    parameter int BL_W   = 5,
    parameter int NCH    = 2
);
    logic [NCH-1:0]        wr_cmd_valid;
    logic [NCH*ADDR_W-1:0] wr_cmd_addr;
    logic [NCH*BL_W-1:0]   wr_cmd_bl_m1;
    logic [NCH-1:0]        wr_data_valid;
    logic [NCH*DATA_W-1:0] wr_data;
    logic [NCH-1:0]        wr_full;
    logic                  rd_req;
    logic [ADDR_W-1:0]     rd_addr;
    logic [BL_W-1:0]       rd_bl_m1;
    logic                  rd_grant;
    logic                  sdrc_act;
    logic [BL_W+ADDR_W:0]  sdrc_cmd;
    logic [DATA_W-1:0]     sdrc_data_in;
    logic                  sdrc_data_in_req;
    logic                  sdrc_ready;

    // controller side
    modport slave (
        input  wr_cmd_valid, wr_cmd_addr, wr_cmd_bl_m1, wr_data_valid, wr_data,
        input  rd_req, rd_addr, rd_bl_m1,
        input  sdrc_data_in_req, sdrc_ready,
        output wr_full, rd_grant, sdrc_act, sdrc_cmd, sdrc_data_in
    );

    // host and sdrc side
    modport master (
        output wr_cmd_valid, wr_cmd_addr, wr_cmd_bl_m1, wr_data_valid, wr_data,
        output rd_req, rd_addr, rd_bl_m1,
        output sdrc_data_in_req, sdrc_ready,
        input  wr_full, rd_grant, sdrc_act, sdrc_cmd, sdrc_data_in
    );
endinterface

// File: rtl/sdrc_mport_ctrl.sv
// rtl/sdrc_mport_ctrl.sv - multi-channel write / single read front-end for sdrc (optional SDRC_MPORT_STARVE_GUARD_EN)
module sdrc_mport_ctrl #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32,
    parameter int BL_W   = 5,
    parameter int NCH    = 2,
    parameter int DLOG2  = 6,
    parameter int CLOG2  = 2
) (
    input  logic             host_clk,
    input  logic             rst_n,
    sdrc_mport_ctrl_if.slave bus
);
    localparam int DDEPTH = 1 << DLOG2;
    localparam int CDEPTH = 1 << CLOG2;
    localparam int DCW    = DLOG2 + 1;
    localparam int CCW    = CLOG2 + 1;
    localparam int CEW    = BL_W + ADDR_W;
    localparam int BCW    = BL_W + 1;
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_WR_ISSUE,
        S_RD_WAIT,
        S_WR_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [NCH-1:0]        elig;
    logic [NCH-1:0]        cmd_pop;
    logic [NCH-1:0]        dat_pop;
    logic [NCH-1:0]        full_v;
    logic [NCH*CEW-1:0]    cmd_head_p;
    logic [NCH*DATA_W-1:0] dat_head_p;

    logic [CH_W-1:0]   gnt_ch_q;
    logic [BL_W-1:0]   gnt_bl_q;
    logic [BCW-1:0]    wcnt_q;
    logic [BCW-1:0]    burst_len;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [CEW:0]      cmd_q;
    logic              rd_first_q;

    logic              found;
    logic [CH_W-1:0]   sel_ch;
    logic [CEW-1:0]    sel_head;
    logic              sel_rd;
    logic              sel_wr;
    logic              pop_ok;
    logic              in_wr;
    logic              guard_force;
    logic [DATA_W-1:0] data_mux;

    // per-channel command and data FIFOs, show-ahead
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CEW-1:0]    cmem [CDEPTH];
        logic [CLOG2-1:0]  c_wptr, c_rptr;
        logic [CCW-1:0]    c_cnt;
        logic [DATA_W-1:0] dmem [DDEPTH];
        logic [DLOG2-1:0]  d_wptr, d_rptr;
        logic [DCW-1:0]    d_cnt;
        logic              c_push, c_pop, d_push, d_pop;
        logic [CEW-1:0]    c_head;

        // a push into a full FIFO is dropped even if a pop happens in the same cycle
        assign c_push = bus.wr_cmd_valid[c] && (c_cnt != CCW'(CDEPTH));
        assign c_pop  = cmd_pop[c] && (c_cnt != '0);
        assign d_push = bus.wr_data_valid[c] && (d_cnt != DCW'(DDEPTH));
        assign d_pop  = dat_pop[c] && (d_cnt != '0);

        assign c_head = cmem[c_rptr];
        assign cmd_head_p[c*CEW +: CEW]       = c_head;
        assign dat_head_p[c*DATA_W +: DATA_W] = dmem[d_rptr];

        // eligible once the whole burst of the head command is buffered
        assign elig[c]   = (c_cnt != '0) && (d_cnt > DCW'(c_head[CEW-1 -: BL_W]));
        assign full_v[c] = (c_cnt == CCW'(CDEPTH)) || (d_cnt == DCW'(DDEPTH));

        // command FIFO pointers and occupancy
        always_ff @(posedge host_clk or negedge rst_n) begin
            if (!rst_n) begin
                c_wptr <= '0;
                c_rptr <= '0;
                c_cnt  <= '0;
            end else begin
                if (c_push) c_wptr <= c_wptr + CLOG2'(1);
                if (c_pop)  c_rptr <= c_rptr + CLOG2'(1);
                c_cnt <= c_cnt + CCW'(c_push) - CCW'(c_pop);
            end
        end

        // command FIFO storage
        always_ff @(posedge host_clk) begin
            if (c_push) cmem[c_wptr] <= {bus.wr_cmd_bl_m1[c*BL_W +: BL_W], bus.wr_cmd_addr[c*ADDR_W +: ADDR_W]};
        end

        // data FIFO pointers and occupancy
        always_ff @(posedge host_clk or negedge rst_n) begin
            if (!rst_n) begin
                d_wptr <= '0;
                d_rptr <= '0;
                d_cnt  <= '0;
            end else begin
                if (d_push) d_wptr <= d_wptr + DLOG2'(1);
                if (d_pop)  d_rptr <= d_rptr + DLOG2'(1);
                d_cnt <= d_cnt + DCW'(d_push) - DCW'(d_pop);
            end
        end

        // data FIFO storage
        always_ff @(posedge host_clk) begin
            if (d_push) dmem[d_wptr] <= bus.wr_data[c*DATA_W +: DATA_W];
        end
    end

    assign bus.wr_full = full_v;

`ifdef SDRC_MPORT_STARVE_GUARD_EN
    logic [2:0] starve_q;

    assign guard_force = (starve_q >= 3'd4) && (|elig);

    // counts read grants that passed over an eligible writer; any write grant clears it
    always_ff @(posedge host_clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (sel_wr) begin
            starve_q <= '0;
        end else if (sel_rd && (|elig) && (starve_q < 3'd4)) begin
            starve_q <= starve_q + 3'd1;
        end
    end
`else
    assign guard_force = 1'b0;
`endif

    // round-robin search for the first eligible writer starting at rr_ptr_q
    always_comb begin
        logic [2*NCH-1:0] rot;
        int               tmp;
        found  = 1'b0;
        sel_ch = '0;
        tmp    = 0;
        rot    = {elig, elig} >> rr_ptr_q;
        for (int j = 0; j < NCH; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                tmp   = int'(rr_ptr_q) + j;
                if (tmp >= NCH) tmp = tmp - NCH;
                sel_ch = CH_W'(tmp);
            end
        end
    end

    // head command of the selected channel, and data head of the granted channel
    always_comb begin
        sel_head = '0;
        data_mux = '0;
        for (int c = 0; c < NCH; c++) begin
            if (sel_ch == CH_W'(c))   sel_head = cmd_head_p[c*CEW +: CEW];
            if (gnt_ch_q == CH_W'(c)) data_mux = dat_head_p[c*DATA_W +: DATA_W];
        end
    end

    assign in_wr     = (state_q == S_WR_ISSUE) || (state_q == S_WR_WAIT);
    assign burst_len = BCW'(gnt_bl_q) + BCW'(1);
    assign pop_ok    = in_wr && bus.sdrc_data_in_req && (wcnt_q < burst_len);

    // next state, arbitration and FIFO pop requests
    always_comb begin
        state_d = state_q;
        sel_rd  = 1'b0;
        sel_wr  = 1'b0;
        cmd_pop = '0;
        dat_pop = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.sdrc_ready) begin
                    if (bus.rd_req && !guard_force) begin
                        sel_rd  = 1'b1;
                        state_d = S_RD_ISSUE;
                    end else if (found) begin
                        sel_wr  = 1'b1;
                        state_d = S_WR_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_WR_ISSUE: state_d = S_WR_WAIT;
            S_RD_WAIT: begin
                if (!rd_first_q && bus.sdrc_ready) state_d = S_IDLE;
            end
            S_WR_WAIT: begin
                if (bus.sdrc_ready && (wcnt_q == burst_len)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        for (int c = 0; c < NCH; c++) begin
            cmd_pop[c] = sel_wr && (sel_ch == CH_W'(c));
            dat_pop[c] = pop_ok && (gnt_ch_q == CH_W'(c));
        end
    end

    // state, grant latch, registered command, burst counter and RR pointer
    always_ff @(posedge host_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_ch_q   <= '0;
            gnt_bl_q   <= '0;
            wcnt_q     <= '0;
            rr_ptr_q   <= '0;
            cmd_q      <= '0;
            rd_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_first_q <= (state_q == S_RD_ISSUE);
            if (sel_rd) cmd_q <= {1'b0, bus.rd_bl_m1, bus.rd_addr};
            if (sel_wr) begin
                cmd_q    <= {1'b1, sel_head};
                gnt_ch_q <= sel_ch;
                gnt_bl_q <= sel_head[CEW-1 -: BL_W];
                wcnt_q   <= '0;
                rr_ptr_q <= (sel_ch == CH_W'(NCH-1)) ? '0 : sel_ch + CH_W'(1);
            end else if (pop_ok) begin
                wcnt_q <= wcnt_q + BCW'(1);
            end
        end
    end

    assign bus.sdrc_act     = (state_q == S_RD_ISSUE) || (state_q == S_WR_ISSUE);
    assign bus.rd_grant     = (state_q == S_RD_ISSUE);
    assign bus.sdrc_cmd     = cmd_q;
    assign bus.sdrc_data_in = in_wr ? data_mux : '0;

endmodule

// File: tb/tb_sdrc_mport_ctrl.sv
// tb/tb_sdrc_mport_ctrl.sv - scoreboard bench for sdrc_mport_ctrl
module tb_sdrc_mport_ctrl;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;
    localparam int BL_W   = 5;
    localparam int NCH    = 2;
    localparam int CMD_W  = 1 + BL_W + ADDR_W;

    logic host_clk = 1'b0;
    logic rst_n    = 1'b0;

    always #5 host_clk = ~host_clk;

    sdrc_mport_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BL_W(BL_W), .NCH(NCH)) bus ();

    sdrc_mport_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BL_W(BL_W), .NCH(NCH), .DLOG2(6), .CLOG2(2)
    ) dut (
        .host_clk(host_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    logic [CMD_W-1:0]  exp_cmd [$];
    logic [DATA_W-1:0] exp_data[$];
    logic [CMD_W-1:0]  mon_cmd;
    logic [DATA_W-1:0] mon_dat;
    int n_cmp    = 0;
    int n_bad    = 0;
    int act_cnt  = 0;
    int cyc      = 0;
    int last_act = -100;
    int pending  = 0;
    int snap;

    function automatic logic [CMD_W-1:0] mk_cmd(input logic wr, input logic [BL_W-1:0] bl,
                                                input logic [ADDR_W-1:0] a);
        return {wr, bl, a};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // monitor and sdrc data model: compare each command strobe and each popped word
    always @(negedge host_clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.sdrc_act) begin
                act_cnt++;
                check("act_spacing", 64'((cyc - last_act) >= 3), 64'd1);
                last_act = cyc;
                if (exp_cmd.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_act: got cmd %0h required no command", bus.sdrc_cmd);
                end else begin
                    mon_cmd = exp_cmd.pop_front();
                    check("sdrc_cmd", 64'(bus.sdrc_cmd), 64'(mon_cmd));
                    check("rd_grant", 64'(bus.rd_grant), 64'(!mon_cmd[CMD_W-1]));
                end
                if (bus.sdrc_cmd[CMD_W-1]) pending = int'(bus.sdrc_cmd[CMD_W-2 -: BL_W]) + 1;
            end
            if (pending > 0) begin
                bus.sdrc_data_in_req = 1'b1;
                pending--;
                if (exp_data.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_data: got %0h required none", bus.sdrc_data_in);
                end else begin
                    mon_dat = exp_data.pop_front();
                    check("sdrc_data_in", 64'(bus.sdrc_data_in), 64'(mon_dat));
                end
            end else begin
                bus.sdrc_data_in_req = 1'b0;
            end
        end
    end

    task automatic push_cmd(input int ch, input logic [ADDR_W-1:0] addr, input logic [BL_W-1:0] bl);
        bus.wr_cmd_addr[ch*ADDR_W +: ADDR_W] = addr;
        bus.wr_cmd_bl_m1[ch*BL_W +: BL_W]    = bl;
        bus.wr_cmd_valid[ch]                 = 1'b1;
        @(negedge host_clk);
        bus.wr_cmd_valid[ch] = 1'b0;
    endtask

    task automatic push_data(input int ch, input logic [DATA_W-1:0] w);
        bus.wr_data[ch*DATA_W +: DATA_W] = w;
        bus.wr_data_valid[ch]            = 1'b1;
        @(negedge host_clk);
        bus.wr_data_valid[ch] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_cmd.size() != 0 || exp_data.size() != 0 || pending != 0) && t < 2000) begin
            @(negedge host_clk);
            #1;
            t++;
        end
        check({"drain_", name}, 64'(t < 2000), 64'd1);
        repeat (4) @(negedge host_clk);
        #1;
    endtask

    task automatic wait_acts(input int target, input string name);
        int t = 0;
        while (act_cnt < target && t < 500) begin
            @(negedge host_clk);
            #1;
            t++;
        end
        check({"acts_", name}, 64'(act_cnt >= target), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_cmd_valid     = '0;
        bus.wr_cmd_addr      = '0;
        bus.wr_cmd_bl_m1     = '0;
        bus.wr_data_valid    = '0;
        bus.wr_data          = '0;
        bus.rd_req           = 1'b0;
        bus.rd_addr          = '0;
        bus.rd_bl_m1         = '0;
        bus.sdrc_data_in_req = 1'b0;
        bus.sdrc_ready       = 1'b1;
        repeat (3) @(negedge host_clk);
        check("rst_act",      64'(bus.sdrc_act),     64'd0);
        check("rst_rd_grant", 64'(bus.rd_grant),     64'd0);
        check("rst_cmd",      64'(bus.sdrc_cmd),     64'd0);
        check("rst_data",     64'(bus.sdrc_data_in), 64'd0);
        check("rst_full",     64'(bus.wr_full),      64'd0);
        rst_n = 1'b1;
        @(negedge host_clk);

        // single write burst on ch0
        exp_cmd.push_back(mk_cmd(1'b1, 5'd3, 22'h100));
        for (int i = 0; i < 4; i++) begin
            exp_data.push_back(32'hA0 + i);
            push_data(0, 32'hA0 + i);
        end
        push_cmd(0, 22'h100, 5'd3);
        wait_drain("single_wr");
        check("idle_data_zero", 64'(bus.sdrc_data_in), 64'd0);

        // incomplete burst on ch1 must wait for its last words
        exp_cmd.push_back(mk_cmd(1'b1, 5'd7, 22'h200));
        for (int i = 0; i < 8; i++) exp_data.push_back(32'hB100 + i);
        for (int i = 0; i < 5; i++) push_data(1, 32'hB100 + i);
        push_cmd(1, 22'h200, 5'd7);
        #1;
        snap = act_cnt;
        repeat (10) @(negedge host_clk);
        #1;
        check("incomplete_no_act", 64'(act_cnt), 64'(snap));
        for (int i = 5; i < 8; i++) push_data(1, 32'hB100 + i);
        #1;
        snap = act_cnt;
        repeat (2) @(negedge host_clk);
        #1;
        check("act_within_2", 64'(act_cnt), 64'(snap + 1));
        wait_drain("incomplete");

        // round-robin between two loaded channels
        bus.sdrc_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int ch = 0; ch < 2; ch++) begin
                exp_cmd.push_back(mk_cmd(1'b1, 5'd1, 22'(24'h10 * (b + 1) + 24'h1000 * ch)));
                for (int w = 0; w < 2; w++) begin
                    exp_data.push_back(32'hC0000 + 32'h100 * ch + 32'h10 * b + w);
                    push_data(ch, 32'hC0000 + 32'h100 * ch + 32'h10 * b + w);
                end
                push_cmd(ch, 22'(24'h10 * (b + 1) + 24'h1000 * ch), 5'd1);
            end
        end
        bus.sdrc_ready = 1'b1;
        wait_drain("round_robin");

        // read has priority over an eligible writer
        bus.sdrc_ready = 1'b0;
        push_data(0, 32'hD0);
        push_cmd(0, 22'h300, 5'd0);
        bus.rd_addr  = 22'h1234;
        bus.rd_bl_m1 = 5'd7;
        bus.rd_req   = 1'b1;
        exp_cmd.push_back(mk_cmd(1'b0, 5'd7, 22'h1234));
        exp_cmd.push_back(mk_cmd(1'b1, 5'd0, 22'h300));
        exp_data.push_back(32'hD0);
        snap = act_cnt;
        bus.sdrc_ready = 1'b1;
        wait_acts(snap + 1, "read_first");
        bus.rd_req = 1'b0;
        wait_drain("read_prio");

`ifdef SDRC_MPORT_STARVE_GUARD_EN
        // held read request yields to a writer after four reads
        bus.sdrc_ready = 1'b0;
        push_data(0, 32'hE0);
        push_cmd(0, 22'h500, 5'd0);
        bus.rd_addr  = 22'h2000;
        bus.rd_bl_m1 = 5'd3;
        bus.rd_req   = 1'b1;
        for (int i = 0; i < 4; i++) exp_cmd.push_back(mk_cmd(1'b0, 5'd3, 22'h2000));
        exp_cmd.push_back(mk_cmd(1'b1, 5'd0, 22'h500));
        exp_data.push_back(32'hE0);
        snap = act_cnt;
        bus.sdrc_ready = 1'b1;
        wait_acts(snap + 5, "starve_guard");
        bus.rd_req = 1'b0;
        wait_drain("starve_guard");
`endif

        // fill ch0 data FIFO, 65th push dropped, then drain two 32-word bursts
        for (int i = 0; i < 63; i++) push_data(0, 32'hF000 + i);
        check("full_after_63", 64'(bus.wr_full), 64'd0);
        push_data(0, 32'hF000 + 63);
        check("full_after_64", 64'(bus.wr_full), 64'd1);
        push_data(0, 32'hDEAD);
        check("full_after_65", 64'(bus.wr_full), 64'd1);
        for (int i = 0; i < 64; i++) exp_data.push_back(32'hF000 + i);
        exp_cmd.push_back(mk_cmd(1'b1, 5'd31, 22'h600));
        exp_cmd.push_back(mk_cmd(1'b1, 5'd31, 22'h620));
        push_cmd(0, 22'h600, 5'd31);
        push_cmd(0, 22'h620, 5'd31);
        wait_drain("overflow");
        check("full_after_drain", 64'(bus.wr_full), 64'd0);

        // reset in the middle of a write burst
        exp_cmd.push_back(mk_cmd(1'b1, 5'd15, 22'h400));
        for (int i = 0; i < 16; i++) begin
            exp_data.push_back(32'h7700 + i);
            push_data(1, 32'h7700 + i);
        end
        #1;
        snap = act_cnt;
        push_cmd(1, 22'h400, 5'd15);
        wait_acts(snap + 1, "mid_burst");
        repeat (3) @(negedge host_clk);
        #1;
        rst_n                = 1'b0;
        pending              = 0;
        bus.sdrc_data_in_req = 1'b0;
        exp_data.delete();
        #1;
        check("midrst_act",   64'(bus.sdrc_act),     64'd0);
        check("midrst_grant", 64'(bus.rd_grant),     64'd0);
        check("midrst_cmd",   64'(bus.sdrc_cmd),     64'd0);
        check("midrst_data",  64'(bus.sdrc_data_in), 64'd0);
        check("midrst_full",  64'(bus.wr_full),      64'd0);
        repeat (2) @(negedge host_clk);
        rst_n = 1'b1;
        #1;
        snap = act_cnt;
        repeat (10) @(negedge host_clk);
        #1;
        check("post_rst_no_act", 64'(act_cnt), 64'(snap));
        exp_cmd.push_back(mk_cmd(1'b1, 5'd1, 22'h440));
        exp_data.push_back(32'h88);
        exp_data.push_back(32'h89);
        push_data(1, 32'h88);
        push_data(1, 32'h89);
        push_cmd(1, 22'h440, 5'd1);
        wait_drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdrc_mport_ctrl.md
# sdrc_mport_ctrl

Multi-channel front-end for the SDRAM controller (sdrc). It accepts write bursts from NCH independent host channels and read requests from one display read port, buffers write commands and data per channel, and arbitrates them onto the single sdrc command/data interface. It is single-clock: host and sdrc run on host_clk. It supersedes the single-channel display controller for the multi-writer frame-buffer path (decoder output, reference-frame writeback).

## Interface
- ADDR_W, 22, SDRAM word address width
- DATA_W, 32, data word width
- BL_W, 5, burst-length-minus-1 field width (max burst 2^BL_W words)
- NCH, 2, number of write channels (1..4)
- DLOG2, 6, log2 depth of each per-channel write-data FIFO; must satisfy DLOG2 > BL_W
- CLOG2, 2, log2 depth of each per-channel write-command FIFO

Ports:
- host_clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low; clock host_clk
- wr_cmd_valid  in  NCH  per-channel command push
- wr_cmd_addr  in  NCH*ADDR_W  packed burst start addresses; channel c occupies bits [c*ADDR_W +: ADDR_W]
- wr_cmd_bl_m1  in  NCH*BL_W  packed burst length minus 1
- wr_data_valid  in  NCH  per-channel data push
- wr_data  in  NCH*DATA_W  packed write data
- wr_full  out  NCH  channel c command FIFO full OR data FIFO full
- rd_req  in  1  level; display read request
- rd_addr  in  ADDR_W  read start address
- rd_bl_m1  in  BL_W  read burst length minus 1
- rd_grant  out  1  one-cycle pulse when the read command is issued
- sdrc_act  out  1  one-cycle command strobe
- sdrc_cmd  out  1+BL_W+ADDR_W  command {write(1)/read(0), bl_m1, addr}, registered
- sdrc_data_in  out  DATA_W  head word of the granted channel's data FIFO (show-ahead)
- sdrc_data_in_req  in  1  sdrc pops one write word
- sdrc_ready  in  1  sdrc can accept a command

## Operation
- Each channel has a command FIFO (2^CLOG2 entries) and a data FIFO (2^DLOG2 entries). Both FIFOs are synchronous and show-ahead.
- A push into a full FIFO is dropped, and that FIFO's contents are unchanged.
- A write channel is eligible when its command FIFO is non-empty and data FIFO count >= head bl_m1+1.
- Arbitration runs in IDLE only, with sdrc_ready=1.
  - rd_req has priority over all write channels.
  - Writes are served round-robin: the search starts at (last granted write channel + 1) mod NCH. The pointer resets to 0.
- State machine:
  - IDLE → RD_ISSUE (read chosen) or WR_ISSUE (write chosen, channel latched in gnt_ch, head command popped).
  - RD_ISSUE: sdrc_act=1, rd_grant=1, sdrc_cmd={0,rd_bl_m1,rd_addr}; → RD_WAIT.
  - WR_ISSUE: sdrc_act=1, sdrc_cmd={1,bl_m1,addr} of the popped entry; → WR_WAIT.
  - RD_WAIT: ignore sdrc_ready in the first cycle, then → IDLE when sdrc_ready=1.
  - WR_WAIT: → IDLE when sdrc_ready=1 AND the burst word counter equals bl_m1+1.
- Data pops:
  - sdrc_data_in_req pops channel gnt_ch's data FIFO only in WR_ISSUE/WR_WAIT, and only while counter < bl_m1+1.
  - Requests at any other time are ignored, with no pop.
  - A request to an empty FIFO cannot occur, because eligibility guarantees the burst is present.
- sdrc_data_in is muxed from gnt_ch's FIFO head. It is 0 in IDLE and in read states.
- Reset clears all FIFOs, the counters and the RR pointer; state goes to IDLE. A burst in flight is abandoned, with no partial command replayed.

## Timing
- Reset values: sdrc_act=0, rd_grant=0, sdrc_cmd=0, sdrc_data_in=0, wr_full=0.
- Arbitration decision in cycle N (IDLE, sdrc_ready=1) → sdrc_act high in cycle N+1 for exactly 1 cycle.
- Minimum spacing between two sdrc_act pulses is 3 cycles.
- Push to pop: a command pushed in cycle N is eligible from cycle N+1, provided its data is complete.
- wr_full is combinational from the FIFO counts. It asserts in the same cycle the FIFO becomes full, as seen by the pushing logic one cycle after the filling push.
- Simultaneous push and pop on the same FIFO when full: the pop proceeds and the push is dropped; the count decreases by 1.

## Configuration
- Macro: SDRC_MPORT_STARVE_GUARD_EN.
- Defined:
  - A 3-bit counter tracks consecutive read grants made while at least one write channel was eligible.
  - When the counter reaches 4, the next arbitration goes to a write even if rd_req=1.
  - Any write grant clears the counter.
- Undefined: strict read priority and no counter logic.

## Test plan
- Single write, ch0: push cmd {addr=0x100, bl_m1=3} plus 4 words (A0..A3), sdrc_ready=1 → sdrc_act one cycle, sdrc_cmd={1,3,0x100}, data A0..A3 on four successive req pops, then IDLE.
- Incomplete data: ch1 cmd bl_m1=7 with only 5 words pushed → no sdrc_act. Push 3 more words → sdrc_act within 2 cycles.
- Round-robin: ch0 and ch1 each hold 3 eligible bursts, no reads → grant order 0,1,0,1,0,1.
- Read priority: rd_req=1 with ch0 eligible → rd_grant and sdrc_cmd={0,rd_bl_m1,rd_addr} first, write after rd_req drops. With STARVE_GUARD_EN and rd_req held high → a write is granted after 4 reads.
- Overflow and reset: fill ch0's data FIFO to 2^DLOG2 → wr_full[0]=1 and a 65th push is dropped. Assert rst_n mid WR_WAIT → outputs 0, FIFOs empty, state IDLE.
